// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: state encoding, default timing constants and counter sizing
// shared by the PLL reset controller and its helpers.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } state_e;

    localparam int DEF_RST_PULSE_CYC    = 16;
    localparam int DEF_LOCK_TIMEOUT_CYC = 50000;
    localparam int DEF_LOCK_STABLE_CYC  = 1024;
    localparam int DEF_MAX_RETRIES      = 7;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous status bit,
// cleared to 0 by an asynchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: sequences the PLL reset pulse, qualifies lock, retries on
// lock timeout and releases the refclk-registered system reset.
module pll_reset_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int MAX_RETRIES      = DEF_MAX_RETRIES
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       lock_ok,
    output logic       fail,
    output logic [7:0] retry_cnt,
    output logic [7:0] lock_lost_cnt
);
    localparam int PW = cnt_w(RST_PULSE_CYC);
    localparam int TW = cnt_w(LOCK_TIMEOUT_CYC);
    localparam int SW = cnt_w(LOCK_STABLE_CYC);
    localparam logic [PW-1:0] P_LAST = PW'(RST_PULSE_CYC - 1);
    localparam logic [TW-1:0] T_LAST = TW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [SW-1:0] S_LAST = SW'(LOCK_STABLE_CYC - 1);
    localparam logic [7:0]    R_MAX  = 8'(MAX_RETRIES);

    state_e        state_q, state_d;
    logic [PW-1:0] pulse_q, pulse_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [7:0]    retry_q, retry_d;
    logic [7:0]    lost_q, lost_d;
    logic          pll_rst_q, sys_rst_q, lock_ok_q, fail_q;
    logic          locked_s;
    logic          timeout;
    logic [7:0]    retry_inc;

    sync_2ff u_sync (
        .clk (refclk),
        .rst (rst),
        .d_i (pll_locked),
        .q_o (locked_s)
    );

    assign timeout   = tmo_q == T_LAST;
    assign retry_inc = retry_q + 8'd1;

    always_comb begin
        state_d = state_q;
        pulse_d = '0;
        tmo_d   = tmo_q;
        stab_d  = stab_q;
        retry_d = retry_q;
        lost_d  = lost_q;
        case (state_q)
            PLL_RST: begin
                tmo_d  = '0;
                stab_d = '0;
                if (pulse_q == P_LAST) state_d = WAIT_LOCK;
                else pulse_d = pulse_q + PW'(1);
            end
            WAIT_LOCK, STABLE: begin
                tmo_d = tmo_q + TW'(1);
                // timeout takes priority over any lock progress in the same cycle
                if (timeout) begin
                    tmo_d   = '0;
                    retry_d = retry_inc;
                    state_d = (retry_inc == R_MAX) ? FAIL : PLL_RST;
                end else if (!locked_s) begin
                    stab_d  = '0;
                    state_d = WAIT_LOCK;
                end else if (state_q == WAIT_LOCK) begin
                    state_d = STABLE;
                end else if (stab_q == S_LAST) begin
                    state_d = RUN;
                    retry_d = '0;
                end else begin
                    stab_d = stab_q + SW'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = PLL_RST;
                    lost_d  = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
                end
            end
            FAIL: state_d = FAIL;
            default: state_d = PLL_RST;
        endcase
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= PLL_RST;
            pulse_q   <= '0;
            tmo_q     <= '0;
            stab_q    <= '0;
            retry_q   <= '0;
            lost_q    <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            lock_ok_q <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pulse_q   <= pulse_d;
            tmo_q     <= tmo_d;
            stab_q    <= stab_d;
            retry_q   <= retry_d;
            lost_q    <= lost_d;
            pll_rst_q <= state_d == PLL_RST;
            sys_rst_q <= state_d != RUN;
            lock_ok_q <= state_d == RUN;
            fail_q    <= state_d == FAIL;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign sys_rst       = sys_rst_q;
    assign lock_ok       = lock_ok_q;
    assign fail          = fail_q;
    assign retry_cnt     = retry_q;
    assign lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb_pll_reset_ctrl: randomized and directed lock waveforms checked through a
// scoreboard fed by a timeline-based reference model of the controller.
module tb_pll_reset_ctrl;
    localparam int P    = 4;
    localparam int TMO  = 100;
    localparam int STB  = 8;
    localparam int MAXR = 3;

    localparam int PH_PULSE = 0;
    localparam int PH_ARMED = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_FAIL  = 3;

    typedef struct packed {
        logic       pr;
        logic       sr;
        logic       lo;
        logic       fl;
        logic [7:0] rc;
        logic [7:0] lc;
    } obs_t;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst, sys_rst, lock_ok, fail;
    logic [7:0] retry_cnt, lock_lost_cnt;

    int checks = 0;
    int failures = 0;

    obs_t sb[$];
    bit   dl[$];
    int   phase, t_end, deadline, streak, retries, lost;
    int   edge_n = 0;

    pll_reset_ctrl #(
        .RST_PULSE_CYC    (P),
        .LOCK_TIMEOUT_CYC (TMO),
        .LOCK_STABLE_CYC  (STB),
        .MAX_RETRIES      (MAXR)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .sys_rst       (sys_rst),
        .lock_ok       (lock_ok),
        .fail          (fail),
        .retry_cnt     (retry_cnt),
        .lock_lost_cnt (lock_lost_cnt)
    );

    always #5 refclk = ~refclk;

    // Model timeline: a reset pulse ends P edges after it starts, an attempt
    // times out TMO edges after the pulse ends, and lock is qualified once
    // STB+1 consecutive synchronised-high decisions fall inside the attempt.
    function automatic void model_reset();
        phase   = PH_PULSE;
        t_end   = edge_n + P;
        streak  = 0;
        retries = 0;
        lost    = 0;
        dl      = '{1'b0, 1'b0};
    endfunction

    function automatic void model_edge(input bit lk);
        bit ls;
        ls = dl.pop_front();
        dl.push_back(lk);
        if (phase == PH_PULSE) begin
            if (edge_n == t_end) begin
                phase    = PH_ARMED;
                deadline = edge_n + TMO;
                streak   = 0;
            end
        end else if (phase == PH_ARMED) begin
            if (edge_n == deadline) begin
                retries++;
                if (retries == MAXR) phase = PH_FAIL;
                else begin
                    phase = PH_PULSE;
                    t_end = edge_n + P;
                end
            end else begin
                streak = ls ? streak + 1 : 0;
                if (streak == STB + 1) begin
                    phase   = PH_RUN;
                    retries = 0;
                end
            end
        end else if (phase == PH_RUN && !ls) begin
            lost  = (lost < 255) ? lost + 1 : 255;
            phase = PH_PULSE;
            t_end = edge_n + P;
        end
    endfunction

    function automatic obs_t expect_now();
        obs_t e;
        e.pr = phase == PH_PULSE;
        e.sr = phase != PH_RUN;
        e.lo = phase == PH_RUN;
        e.fl = phase == PH_FAIL;
        e.rc = 8'(retries);
        e.lc = 8'(lost);
        return e;
    endfunction

    always @(negedge refclk) begin
        obs_t e, a;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = {pll_rst, sys_rst, lock_ok, fail, retry_cnt, lock_lost_cnt};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL scoreboard edge=%0d got pr=%b sr=%b lo=%b fl=%b rc=%0d lc=%0d exp pr=%b sr=%b lo=%b fl=%b rc=%0d lc=%0d",
                         edge_n, a.pr, a.sr, a.lo, a.fl, a.rc, a.lc, e.pr, e.sr, e.lo, e.fl, e.rc, e.lc);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got %0d exp %0d", nm, got, exp);
        end
    endtask

    task automatic step(input bit lk, input bit r);
        @(negedge refclk);
        pll_locked = lk;
        rst = r;
        @(posedge refclk);
        edge_n++;
        if (r) model_reset();
        else model_edge(lk);
        sb.push_back(expect_now());
    endtask

    task automatic hold(input bit lk, input int n);
        repeat (n) step(lk, 1'b0);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        sb.delete();
        model_reset();
        #1;
        chk({tag, "_pll_rst"}, int'(pll_rst), 1);
        chk({tag, "_sys_rst"}, int'(sys_rst), 1);
        chk({tag, "_lock_ok"}, int'(lock_ok), 0);
        chk({tag, "_fail"}, int'(fail), 0);
        chk({tag, "_retry_cnt"}, int'(retry_cnt), 0);
        chk({tag, "_lock_lost_cnt"}, int'(lock_lost_cnt), 0);
        repeat (2) step(1'b0, 1'b1);
    endtask

    initial begin
        model_reset();
        repeat (3) step(1'b0, 1'b1);
        // clean lock
        hold(0, 10);
        hold(1, 30);
        chk("clean_lock_ok", int'(lock_ok), 1);
        // lock loss in RUN, then relock
        hold(0, 3);
        hold(1, 30);
        chk("relock_lost_cnt", int'(lock_lost_cnt), 1);
        // reset in the middle of STABLE
        async_reset("rst_run");
        hold(0, 8);
        hold(1, 5);
        async_reset("rst_stable");
        // glitch while qualifying
        hold(0, 6);
        hold(1, 5);
        hold(0, 3);
        hold(1, 30);
        // timeouts until FAIL
        async_reset("rst_pre_timeout");
        hold(0, 3 * (P + TMO) + 30);
        chk("timeout_fail", int'(fail), 1);
        chk("timeout_pll_rst", int'(pll_rst), 0);
        chk("timeout_sys_rst", int'(sys_rst), 1);
        async_reset("rst_fail");
        // lock_lost_cnt saturation
        hold(0, 10);
        hold(1, 20);
        repeat (300) begin
            hold(0, 3);
            hold(1, 20);
        end
        chk("sat_lock_lost_cnt", int'(lock_lost_cnt), 255);
        async_reset("rst_sat");
        // random lock waveforms with occasional resets
        repeat (80) begin
            if ($urandom_range(0, 11) == 0) async_reset("rst_rand");
            hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 40)));
        end
        @(negedge refclk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
